// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the RAM arbiter: FSM state encodings, owner codes,
// the data word returned on a timed-out read, and the grant-selection helper.
// Imported by ram_arbiter and ram_arb_watchdog.
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_VID = 1'b1;

  localparam logic [31:0] RAM_ARB_ERR_DATA = 32'hFFFF_FFFF;

  // Chooses the next owner given at least one active request.
  // Urgent video beats everything; a tie goes to whoever did not win last.
  function automatic logic arb_pick(input logic cpu_req,
                                    input logic vid_req,
                                    input logic vid_urgent,
                                    input logic last_grant);
    logic pick;
    if (vid_req && vid_urgent) begin
      pick = OWN_VID;
    end else if (cpu_req && vid_req) begin
      pick = (last_grant == OWN_VID) ? OWN_CPU : OWN_VID;
    end else if (cpu_req) begin
      pick = OWN_CPU;
    end else begin
      pick = OWN_VID;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ram_arb_watchdog.sv
// ---------------------------------------------------------------------------
// ram_arb_watchdog
// Per-transaction timeout counter for the RAM arbiter. Cleared on each grant,
// counts while the arbiter is busy, and flags expiry once it has counted
// TIMEOUT_CYCLES-1 busy cycles without a RAM response.
// Only instantiated when RAM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       grant strobe; restarts the count from zero
//   run         arbiter is waiting on the RAM
//   expire      limit reached while running
// ---------------------------------------------------------------------------
module ram_arb_watchdog
  import ram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = run && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Two-requester arbiter/sequencer for the single external RAM port. The CPU
// bus (read/write) and the video scan-out fetcher (read-only) share the RAM;
// one transaction is in flight at a time, via an IDLE -> BUSY -> DONE FSM.
// Optional feature: define RAM_ARB_TIMEOUT_EN to add a per-transaction
// watchdog (parameter TIMEOUT_CYCLES) that completes a hung transaction with
// error data and sets the sticky arb_error flag.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_address/rd/wr/data/mask  CPU request side (level requests)
//   cpu_rd_data/rd_valid/wr_ack  CPU completion (one-cycle pulses)
//   vid_address/rd_enable/urgent video request side
//   vid_rd_data/rd_valid         video completion
//   ram_*                        RAM controller port
//   arb_owner                    current/last grant (0=CPU, 1=video)
//   arb_error                    sticky timeout flag
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] cpu_address,
  input  logic        cpu_rd_enable,
  input  logic        cpu_wr_enable,
  input  logic [31:0] cpu_wr_data,
  input  logic [3:0]  cpu_wr_mask,
  output logic [31:0] cpu_rd_data,
  output logic        cpu_rd_valid,
  output logic        cpu_wr_ack,
  input  logic [29:0] vid_address,
  input  logic        vid_rd_enable,
  input  logic        vid_urgent,
  output logic [31:0] vid_rd_data,
  output logic        vid_rd_valid,
  output logic [29:0] ram_address,
  output logic        ram_rd_enable,
  output logic        ram_wr_enable,
  output logic [31:0] ram_wr_data,
  output logic [3:0]  ram_wr_mask,
  input  logic [31:0] ram_rd_data,
  input  logic        ram_rd_valid,
  input  logic        ram_wr_ack,
  output logic        arb_owner,
  output logic        arb_error
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [29:0] ram_address_q, ram_address_d;
  logic        ram_rd_enable_q, ram_rd_enable_d;
  logic        ram_wr_enable_q, ram_wr_enable_d;
  logic [31:0] ram_wr_data_q, ram_wr_data_d;
  logic [3:0]  ram_wr_mask_q, ram_wr_mask_d;
  logic [31:0] cpu_rd_data_q, cpu_rd_data_d;
  logic        cpu_rd_valid_q, cpu_rd_valid_d;
  logic        cpu_wr_ack_q, cpu_wr_ack_d;
  logic [31:0] vid_rd_data_q, vid_rd_data_d;
  logic        vid_rd_valid_q, vid_rd_valid_d;
  logic        error_q, error_d;

  logic        cpu_req, vid_req;
  logic        grant;
  logic        pick;
  logic        rd_done, wr_done;
  logic        wd_expire;
  logic [31:0] rsp_data;

  assign cpu_req = cpu_rd_enable | cpu_wr_enable;
  assign vid_req = vid_rd_enable;

  // Only the response matching the issued kind counts; anything else is noise.
  assign rd_done = (state_q == ARB_BUSY) && ram_rd_enable_q && ram_rd_valid;
  assign wr_done = (state_q == ARB_BUSY) && ram_wr_enable_q && ram_wr_ack;

`ifdef RAM_ARB_TIMEOUT_EN
  ram_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (grant),
    .run    (state_q == ARB_BUSY),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    ram_address_d   = ram_address_q;
    ram_rd_enable_d = ram_rd_enable_q;
    ram_wr_enable_d = ram_wr_enable_q;
    ram_wr_data_d   = ram_wr_data_q;
    ram_wr_mask_d   = ram_wr_mask_q;
    cpu_rd_data_d   = cpu_rd_data_q;
    cpu_rd_valid_d  = 1'b0;
    cpu_wr_ack_d    = 1'b0;
    vid_rd_data_d   = vid_rd_data_q;
    vid_rd_valid_d  = 1'b0;
    error_d         = error_q;
    grant           = 1'b0;
    pick            = arb_pick(cpu_req, vid_req, vid_urgent, last_grant_q);
    rsp_data        = rd_done ? ram_rd_data : RAM_ARB_ERR_DATA;

    unique case (state_q)
      ARB_IDLE: begin
        if (cpu_req || vid_req) begin
          grant        = 1'b1;
          state_d      = ARB_BUSY;
          owner_d      = pick;
          last_grant_d = pick;
          if (pick == OWN_VID) begin
            ram_address_d   = vid_address;
            ram_rd_enable_d = 1'b1;
            ram_wr_enable_d = 1'b0;
            ram_wr_data_d   = '0;
            ram_wr_mask_d   = '0;
          end else if (cpu_wr_enable) begin
            // A simultaneous CPU read is left pending behind the write.
            ram_address_d   = cpu_address;
            ram_rd_enable_d = 1'b0;
            ram_wr_enable_d = 1'b1;
            ram_wr_data_d   = cpu_wr_data;
            ram_wr_mask_d   = cpu_wr_mask;
          end else begin
            ram_address_d   = cpu_address;
            ram_rd_enable_d = 1'b1;
            ram_wr_enable_d = 1'b0;
            ram_wr_data_d   = '0;
            ram_wr_mask_d   = '0;
          end
        end
      end

      ARB_BUSY: begin
        if (rd_done || wr_done || wd_expire) begin
          state_d         = ARB_DONE;
          ram_rd_enable_d = 1'b0;
          ram_wr_enable_d = 1'b0;
          if (!(rd_done || wr_done)) begin
            error_d = 1'b1;
          end
          if (ram_wr_enable_q) begin
            cpu_wr_ack_d = 1'b1;
          end else if (owner_q == OWN_VID) begin
            vid_rd_valid_d = 1'b1;
            vid_rd_data_d  = rsp_data;
          end else begin
            cpu_rd_valid_d = 1'b1;
            cpu_rd_data_d  = rsp_data;
          end
        end
      end

      // Guard cycle: the requester is still dropping its level request,
      // so nothing is sampled here.
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ARB_IDLE;
      owner_q         <= OWN_CPU;
      last_grant_q    <= OWN_VID;
      ram_address_q   <= '0;
      ram_rd_enable_q <= 1'b0;
      ram_wr_enable_q <= 1'b0;
      ram_wr_data_q   <= '0;
      ram_wr_mask_q   <= '0;
      cpu_rd_data_q   <= '0;
      cpu_rd_valid_q  <= 1'b0;
      cpu_wr_ack_q    <= 1'b0;
      vid_rd_data_q   <= '0;
      vid_rd_valid_q  <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      ram_address_q   <= ram_address_d;
      ram_rd_enable_q <= ram_rd_enable_d;
      ram_wr_enable_q <= ram_wr_enable_d;
      ram_wr_data_q   <= ram_wr_data_d;
      ram_wr_mask_q   <= ram_wr_mask_d;
      cpu_rd_data_q   <= cpu_rd_data_d;
      cpu_rd_valid_q  <= cpu_rd_valid_d;
      cpu_wr_ack_q    <= cpu_wr_ack_d;
      vid_rd_data_q   <= vid_rd_data_d;
      vid_rd_valid_q  <= vid_rd_valid_d;
      error_q         <= error_d;
    end
  end

  assign cpu_rd_data   = cpu_rd_data_q;
  assign cpu_rd_valid  = cpu_rd_valid_q;
  assign cpu_wr_ack    = cpu_wr_ack_q;
  assign vid_rd_data   = vid_rd_data_q;
  assign vid_rd_valid  = vid_rd_valid_q;
  assign ram_address   = ram_address_q;
  assign ram_rd_enable = ram_rd_enable_q;
  assign ram_wr_enable = ram_wr_enable_q;
  assign ram_wr_data   = ram_wr_data_q;
  assign ram_wr_mask   = ram_wr_mask_q;
  assign arb_owner     = owner_q;
  assign arb_error     = error_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter. The bench plays the CPU, the video fetcher
// and the RAM controller. Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point, well away from the next edge.
// Define RAM_ARB_TIMEOUT_EN to include the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] cpu_address;
  logic        cpu_rd_enable;
  logic        cpu_wr_enable;
  logic [31:0] cpu_wr_data;
  logic [3:0]  cpu_wr_mask;
  logic [31:0] cpu_rd_data;
  logic        cpu_rd_valid;
  logic        cpu_wr_ack;
  logic [29:0] vid_address;
  logic        vid_rd_enable;
  logic        vid_urgent;
  logic [31:0] vid_rd_data;
  logic        vid_rd_valid;
  logic [29:0] ram_address;
  logic        ram_rd_enable;
  logic        ram_wr_enable;
  logic [31:0] ram_wr_data;
  logic [3:0]  ram_wr_mask;
  logic [31:0] ram_rd_data;
  logic        ram_rd_valid;
  logic        ram_wr_ack;
  logic        arb_owner;
  logic        arb_error;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.TIMEOUT_CYCLES(16)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_address   (cpu_address),
    .cpu_rd_enable (cpu_rd_enable),
    .cpu_wr_enable (cpu_wr_enable),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_wr_mask   (cpu_wr_mask),
    .cpu_rd_data   (cpu_rd_data),
    .cpu_rd_valid  (cpu_rd_valid),
    .cpu_wr_ack    (cpu_wr_ack),
    .vid_address   (vid_address),
    .vid_rd_enable (vid_rd_enable),
    .vid_urgent    (vid_urgent),
    .vid_rd_data   (vid_rd_data),
    .vid_rd_valid  (vid_rd_valid),
    .ram_address   (ram_address),
    .ram_rd_enable (ram_rd_enable),
    .ram_wr_enable (ram_wr_enable),
    .ram_wr_data   (ram_wr_data),
    .ram_wr_mask   (ram_wr_mask),
    .ram_rd_data   (ram_rd_data),
    .ram_rd_valid  (ram_rd_valid),
    .ram_wr_ack    (ram_wr_ack),
    .arb_owner     (arb_owner),
    .arb_error     (arb_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    cpu_address   = '0;
    cpu_rd_enable = 1'b0;
    cpu_wr_enable = 1'b0;
    cpu_wr_data   = '0;
    cpu_wr_mask   = '0;
    vid_address   = '0;
    vid_rd_enable = 1'b0;
    vid_urgent    = 1'b0;
    ram_rd_data   = '0;
    ram_rd_valid  = 1'b0;
    ram_wr_ack    = 1'b0;
    tick();
    tick();
    chk({tag, " ctrl"}, {25'd0, ram_rd_enable, ram_wr_enable, cpu_rd_valid, cpu_wr_ack,
                         vid_rd_valid, arb_owner, arb_error}, 32'd0);
    chk({tag, " addr"}, {2'b00, ram_address}, 32'd0);
    chk({tag, " cpu_data"}, cpu_rd_data, 32'd0);
    chk({tag, " vid_data"}, vid_rd_data, 32'd0);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a RAM strobe; n is the number of edges it took.
  task automatic wait_grant(input string tag, output int n);
    n = 0;
    while (!(ram_rd_enable || ram_wr_enable) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " granted"}, {31'd0, ram_rd_enable | ram_wr_enable}, 32'd1);
  endtask

  // One complete transaction as seen from the RAM side. Entered just after
  // an edge with requests already set up; returns one cycle after DONE.
  // drop[0]/drop[1] withdraw the CPU/video requests in the pulse cycle.
  task automatic do_txn(input string tag, input logic exp_own, input logic exp_wr,
                        input logic [29:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_mask, input int lat,
                        input logic [31:0] rdata, input logic bogus,
                        input logic [1:0] drop, output int waited);
    wait_grant(tag, waited);
    chk({tag, " owner"}, {31'd0, arb_owner}, {31'd0, exp_own});
    chk({tag, " kind"}, {30'd0, ram_wr_enable, ram_rd_enable}, {30'd0, exp_wr, !exp_wr});
    chk({tag, " addr"}, {2'b00, ram_address}, {2'b00, exp_addr});
    chk({tag, " mask"}, {28'd0, ram_wr_mask}, {28'd0, exp_mask});
    if (exp_wr) chk({tag, " wdata"}, ram_wr_data, exp_wdata);
    if (bogus) begin
      ram_rd_valid = exp_wr;
      ram_wr_ack   = !exp_wr;
      tick();
      ram_rd_valid = 1'b0;
      ram_wr_ack   = 1'b0;
      chk({tag, " bogus ignored"}, {28'd0, ram_rd_enable | ram_wr_enable, cpu_rd_valid,
                                    cpu_wr_ack, vid_rd_valid}, 32'h8);
    end
    repeat (lat - 1) tick();
    chk({tag, " held"}, {31'd0, ram_rd_enable | ram_wr_enable}, 32'd1);
    ram_rd_data  = rdata;
    ram_rd_valid = !exp_wr;
    ram_wr_ack   = exp_wr;
    tick();
    ram_rd_valid = 1'b0;
    ram_wr_ack   = 1'b0;
    chk({tag, " pulse"}, {27'd0, ram_rd_enable, ram_wr_enable, cpu_rd_valid, cpu_wr_ack,
                          vid_rd_valid},
        {27'd0, 1'b0, 1'b0, !exp_own && !exp_wr, !exp_own && exp_wr, exp_own});
    if (!exp_wr && !exp_own) chk({tag, " cpu_rdata"}, cpu_rd_data, rdata);
    if (exp_own) chk({tag, " vid_rdata"}, vid_rd_data, rdata);
    if (drop[0]) begin
      cpu_rd_enable = 1'b0;
      cpu_wr_enable = 1'b0;
    end
    if (drop[1]) vid_rd_enable = 1'b0;
    tick();
    chk({tag, " pulse end"}, {29'd0, cpu_rd_valid, cpu_wr_ack, vid_rd_valid}, 32'd0);
  endtask

  initial begin
    int n;
    logic own;

    // 1: single CPU read, RAM answers 4 cycles after the strobe
    do_reset("t1 reset");
    cpu_address   = 30'h0000_1000;
    cpu_rd_enable = 1'b1;
    do_txn("t1", 1'b0, 1'b0, 30'h0000_1000, 32'd0, 4'b0000, 4, 32'hDEAD_BEEF, 1'b0,
           2'b01, n);
    chk("t1 latency", n, 32'd1);
    tick();
    chk("t1 no reissue", {31'd0, ram_rd_enable | ram_wr_enable}, 32'd0);
`ifndef RAM_ARB_TIMEOUT_EN
    chk("t1 arb_error", {31'd0, arb_error}, 32'd0);
`endif

    // 2: CPU write and video read raised on the same edge after reset
    do_reset("t2 reset");
    cpu_address   = 30'h0000_0040;
    cpu_wr_data   = 32'h1234_5678;
    cpu_wr_mask   = 4'b0011;
    cpu_wr_enable = 1'b1;
    vid_address   = 30'h0002_0000;
    vid_rd_enable = 1'b1;
    do_txn("t2 cpu", 1'b0, 1'b1, 30'h0000_0040, 32'h1234_5678, 4'b0011, 2, 32'd0, 1'b0,
           2'b01, n);
    do_txn("t2 vid", 1'b1, 1'b0, 30'h0002_0000, 32'd0, 4'b0000, 1, 32'hCAFE_F00D, 1'b0,
           2'b10, n);
    chk("t2 cpu_rdata held", cpu_rd_data, 32'd0);

    // 3: both held continuously; video won last so the CPU goes first
    cpu_address   = 30'h0000_0100;
    cpu_rd_enable = 1'b1;
    vid_address   = 30'h0000_0200;
    vid_rd_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      own = i[0];
      do_txn($sformatf("t3 txn%0d", i), own, 1'b0, own ? 30'h0000_0200 : 30'h0000_0100,
             32'd0, 4'b0000, 1 + i % 3, 32'hA000_0000 + i, 1'b0,
             (i == 5) ? 2'b11 : 2'b00, n);
    end
    tick();
    tick();
    chk("t3 idle after drop", {31'd0, ram_rd_enable | ram_wr_enable}, 32'd0);

    // 4: urgent video beats a pending CPU even though video won last;
    //    a wrong-kind response is ignored; CPU rd+wr together services the write
    do_reset("t4 reset");
    cpu_address   = 30'h0000_0300;
    cpu_rd_enable = 1'b1;
    vid_address   = 30'h0000_0400;
    vid_rd_enable = 1'b1;
    vid_urgent    = 1'b1;
    do_txn("t4 urgent", 1'b1, 1'b0, 30'h0000_0400, 32'd0, 4'b0000, 2, 32'h0BAD_CAFE,
           1'b1, 2'b10, n);
    vid_urgent = 1'b0;
    do_txn("t4 cpu", 1'b0, 1'b0, 30'h0000_0300, 32'd0, 4'b0000, 1, 32'h1111_2222,
           1'b0, 2'b01, n);
    cpu_rd_enable = 1'b1;
    cpu_wr_enable = 1'b1;
    cpu_wr_data   = 32'h8765_4321;
    cpu_wr_mask   = 4'b1100;
    do_txn("t4 rdwr", 1'b0, 1'b1, 30'h0000_0300, 32'h8765_4321, 4'b1100, 1, 32'd0,
           1'b0, 2'b00, n);
    cpu_wr_enable = 1'b0;
    do_txn("t4 rd after wr", 1'b0, 1'b0, 30'h0000_0300, 32'd0, 4'b0000, 1,
           32'h3333_4444, 1'b0, 2'b01, n);

    // 5: reset mid-BUSY, then a stale RAM valid
    do_reset("t5 reset");
    cpu_address   = 30'h0000_0500;
    cpu_rd_enable = 1'b1;
    wait_grant("t5", n);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 async clear", {27'd0, ram_rd_enable, ram_wr_enable, cpu_rd_valid,
                           vid_rd_valid, arb_owner}, 32'd0);
    chk("t5 addr clear", {2'b00, ram_address}, 32'd0);
    cpu_rd_enable = 1'b0;
    tick();
    rst_n        = 1'b1;
    ram_rd_data  = 32'h55AA_55AA;
    ram_rd_valid = 1'b1;
    tick();
    ram_rd_valid = 1'b0;
    chk("t5 late valid", {29'd0, cpu_rd_valid, vid_rd_valid, ram_rd_enable}, 32'd0);
    tick();
    chk("t5 late valid 2", {29'd0, cpu_rd_valid, vid_rd_valid, ram_rd_enable}, 32'd0);
    chk("t5 cpu_rdata", cpu_rd_data, 32'd0);

`ifdef RAM_ARB_TIMEOUT_EN
    // 6: RAM never answers; watchdog completes after 16 busy cycles
    do_reset("t6 reset");
    cpu_address   = 30'h0000_03FF;
    cpu_rd_enable = 1'b1;
    wait_grant("t6", n);
    repeat (15) tick();
    chk("t6 still busy", {29'd0, ram_rd_enable, cpu_rd_valid, arb_error}, 32'h4);
    tick();
    chk("t6 timeout pulse", {29'd0, ram_rd_enable, cpu_rd_valid, arb_error}, 32'h3);
    chk("t6 err data", cpu_rd_data, 32'hFFFF_FFFF);
    cpu_rd_enable = 1'b0;
    tick();
    tick();
    chk("t6 sticky", {30'd0, cpu_rd_valid, arb_error}, 32'h1);
    do_reset("t6 clear");
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
